noc_switch_xbar: RTL and testbench

Parametrised switch-allocation and crossbar stage for the mesh router. It takes one-hot route requests from each input port, arbitrates every output with its own round-robin arbiter, and drives registered output flits with per-output backpressure. It replaces a fixed 5-port allocator that relies on external arbitration results, and sits between the routing-computation stage and the output links.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/noc_switch_xbar_if.sv | 37 +++
 rtl/noc_switch_xbar_rr_arbiter.sv | 46 ++++
 rtl/noc_switch_xbar.sv | 124 ++++++++++++
 tb/tb_noc_switch_xbar.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared constants for the mesh router switch stage.
// Flit layout (MSB first): src[4] | dst[4] | timestamp[8] | data[22] | type[2].
package noc_pkg;

    // Default router radix and flit width
    localparam int unsigned NPORT_DEF = 5;
    localparam int unsigned DATASIZE  = 40;

    // Flit field widths
    localparam int unsigned FLIT_TYPE_W = 2;
    localparam int unsigned FLIT_DATA_W = 22;
    localparam int unsigned FLIT_TS_W   = 8;
    localparam int unsigned FLIT_DST_W  = 4;
    localparam int unsigned FLIT_SRC_W  = 4;

    // Flit field offsets (LSB position)
    localparam int unsigned FLIT_TYPE_LSB = 0;
    localparam int unsigned FLIT_DATA_LSB = FLIT_TYPE_LSB + FLIT_TYPE_W;
    localparam int unsigned FLIT_TS_LSB   = FLIT_DATA_LSB + FLIT_DATA_W;
    localparam int unsigned FLIT_DST_LSB  = FLIT_TS_LSB + FLIT_TS_W;
    localparam int unsigned FLIT_SRC_LSB  = FLIT_DST_LSB + FLIT_DST_W;

    // Mesh port indices
    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_W = 1;
    localparam int unsigned PORT_N = 2;
    localparam int unsigned PORT_E = 3;
    localparam int unsigned PORT_S = 4;

endpackage

// File: rtl/noc_switch_xbar_if.sv
// noc_switch_xbar_if: request/flit bundle between route computation, the
// switch stage and the output links. stall_cnt exists only when
// NOC_XBAR_STALL_CNT_EN is defined.
interface noc_switch_xbar_if #(
    parameter int unsigned NPORT    = 5,
    parameter int unsigned DATASIZE = 40,
    parameter int unsigned CNTW     = 8
);
    logic [NPORT*NPORT-1:0]    in_req;
    logic [NPORT*DATASIZE-1:0] in_data;
    logic [NPORT-1:0]          in_ready;
    logic [NPORT-1:0]          out_full;
    logic [NPORT*NPORT-1:0]    grant;
    logic [NPORT-1:0]          out_valid;
    logic [NPORT*DATASIZE-1:0] out_data;
`ifdef NOC_XBAR_STALL_CNT_EN
    logic [NPORT*CNTW-1:0]     stall_cnt;

    modport master (
        output in_req, in_data, out_full,
        input  in_ready, grant, out_valid, out_data, stall_cnt
    );
    modport slave (
        input  in_req, in_data, out_full,
        output in_ready, grant, out_valid, out_data, stall_cnt
    );
`else
    modport master (
        output in_req, in_data, out_full,
        input  in_ready, grant, out_valid, out_data
    );
    modport slave (
        input  in_req, in_data, out_full,
        output in_ready, grant, out_valid, out_data
    );
`endif
endinterface

// File: rtl/noc_switch_xbar_rr_arbiter.sv
// rr_arbiter: round-robin arbiter. The search starts at ptr and wraps; the
// first requester wins when enabled, and ptr moves to one past the winner.
module rr_arbiter #(
    parameter int unsigned NPORT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] req,
    input  logic             en,
    output logic [NPORT-1:0] gnt
);
    localparam int unsigned PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [PTRW-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     idx;

    // Pick the first requester at or after ptr, wrapping; compute next ptr
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == NPORT - 1) ? '0 : PTRW'(idx + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/noc_switch_xbar.sv
// noc_switch_xbar: switch allocation + crossbar with registered outputs and
// per-output backpressure. Optional per-output stall counters are built when
// NOC_XBAR_STALL_CNT_EN is defined.
module noc_switch_xbar
    import noc_pkg::*;
#(
    parameter int unsigned NPORT    = noc_pkg::NPORT_DEF,
    parameter int unsigned DATASIZE = noc_pkg::DATASIZE,
    parameter int unsigned CNTW     = 8
) (
    input logic             clk,
    input logic             rst_n,
    noc_switch_xbar_if.slave bus
);
    logic [NPORT-1:0][NPORT-1:0] req_m;  // [input][output], lowest bit only
    logic [NPORT-1:0][NPORT-1:0] cand;   // [output][input]
    logic [NPORT-1:0][NPORT-1:0] gnt;    // [output][input]

    // Keep only the lowest set request bit of each input
    always_comb begin
        req_m = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            req_m[i] = bus.in_req[i*NPORT +: NPORT]
                     & (~bus.in_req[i*NPORT +: NPORT] + NPORT'(1));
        end
    end

    // Transpose masked requests into per-output candidate vectors
    always_comb begin
        cand = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            for (int unsigned i = 0; i < NPORT; i++) begin
                cand[o][i] = req_m[i][o];
            end
        end
    end

    // Input is consumed when idle or granted by any output
    always_comb begin
        bus.in_ready = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            bus.in_ready[i] = ~|req_m[i];
            for (int unsigned o = 0; o < NPORT; o++) begin
                bus.in_ready[i] = bus.in_ready[i] | gnt[o][i];
            end
        end
    end

    assign bus.grant = gnt;

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        logic                out_valid_q, out_valid_d;
        logic [DATASIZE-1:0] out_data_q, out_data_d;
        logic [DATASIZE-1:0] mux;

        rr_arbiter #(.NPORT(NPORT)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (cand[o]),
            .en    (~bus.out_full[o]),
            .gnt   (gnt[o])
        );

        // Crossbar mux: grant is one-hot or zero, so OR-reduce the slices
        always_comb begin
            mux = '0;
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (gnt[o][i]) begin
                    mux = mux | bus.in_data[i*DATASIZE +: DATASIZE];
                end
            end
        end

        // Load the output register unless downstream is full
        always_comb begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            if (!bus.out_full[o]) begin
                out_valid_d = |gnt[o];
                out_data_d  = mux;
            end
        end

        // Output flit register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign bus.out_valid[o]                       = out_valid_q;
        assign bus.out_data[o*DATASIZE +: DATASIZE]   = out_data_q;

`ifdef NOC_XBAR_STALL_CNT_EN
        logic [CNTW-1:0] stall_q, stall_d;

        // Count blocked cycles with a pending candidate; clear after a grant
        always_comb begin
            stall_d = stall_q;
            if (|gnt[o]) begin
                stall_d = '0;
            end else if (bus.out_full[o] && |cand[o] && stall_q != '1) begin
                stall_d = stall_q + CNTW'(1);
            end
        end

        // Stall counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_d;
            end
        end

        assign bus.stall_cnt[o*CNTW +: CNTW] = stall_q;
`endif
    end

endmodule

// File: tb/tb_noc_switch_xbar.sv
// tb_noc_switch_xbar: directed scenarios plus randomized traffic checked
// against a behavioural model of the switch stage.
module tb_noc_switch_xbar;
    localparam int unsigned NPORT    = 5;
    localparam int unsigned DATASIZE = 40;
`ifdef NOC_XBAR_STALL_CNT_EN
    localparam int unsigned CNTW     = 4;
`else
    localparam int unsigned CNTW     = 8;
`endif

    logic clk = 1'b0;
    logic rst_n;

    noc_switch_xbar_if #(.NPORT(NPORT), .DATASIZE(DATASIZE), .CNTW(CNTW)) bus ();

    noc_switch_xbar #(.NPORT(NPORT), .DATASIZE(DATASIZE), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned               m_ptr   [NPORT];
    int unsigned               m_stall [NPORT];
    logic [NPORT-1:0]          m_ov;
    logic [NPORT*DATASIZE-1:0] m_od;
    int                        e_win   [NPORT];
    logic [NPORT-1:0]          e_cand;
    logic [NPORT*NPORT-1:0]    e_grant;
    logic [NPORT-1:0]          e_ready;

    function automatic int target_of(input int i);
        logic [NPORT-1:0] r;
        r = bus.in_req[i*NPORT +: NPORT];
        for (int b = 0; b < NPORT; b++) if (r[b]) return b;
        return -1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NPORT; o++) begin
            m_ptr[o]   = 0;
            m_stall[o] = 0;
        end
        m_ov = '0;
        m_od = '0;
    endtask

    // Winner = candidate with the smallest circular distance from ptr
    task automatic model_comb();
        int tgt [NPORT];
        int best_d;
        for (int i = 0; i < NPORT; i++) tgt[i] = target_of(i);
        e_grant = '0;
        e_cand  = '0;
        for (int o = 0; o < NPORT; o++) begin
            e_win[o] = -1;
            best_d   = NPORT;
            for (int i = 0; i < NPORT; i++) begin
                if (tgt[i] == o) begin
                    e_cand[o] = 1'b1;
                    if ((i + NPORT - int'(m_ptr[o])) % NPORT < best_d) begin
                        best_d   = (i + NPORT - int'(m_ptr[o])) % NPORT;
                        e_win[o] = i;
                    end
                end
            end
            if (bus.out_full[o]) e_win[o] = -1;
            if (e_win[o] >= 0) e_grant[o*NPORT + e_win[o]] = 1'b1;
        end
        for (int i = 0; i < NPORT; i++) begin
            e_ready[i] = (tgt[i] < 0) || (tgt[i] >= 0 && e_win[tgt[i]] == i);
        end
    endtask

    task automatic model_clock();
        for (int o = 0; o < NPORT; o++) begin
            if (!bus.out_full[o]) begin
                m_ov[o] = (e_win[o] >= 0);
                m_od[o*DATASIZE +: DATASIZE] = (e_win[o] >= 0) ?
                    bus.in_data[e_win[o]*DATASIZE +: DATASIZE] : '0;
                if (e_win[o] >= 0) m_ptr[o] = (e_win[o] + 1) % NPORT;
            end
            if (e_win[o] >= 0) m_stall[o] = 0;
            else if (bus.out_full[o] && e_cand[o] && m_stall[o] < (1 << CNTW) - 1)
                m_stall[o] = m_stall[o] + 1;
        end
    endtask

    // Called just after a falling edge with inputs applied
    task automatic settle();
        #1;
        model_comb();
        check_eq("grant", bus.grant, e_grant);
        check_eq("in_ready", bus.in_ready, e_ready);
        check_eq("out_valid", bus.out_valid, m_ov);
        check_eq("out_data", bus.out_data, m_od);
`ifdef NOC_XBAR_STALL_CNT_EN
        for (int o = 0; o < NPORT; o++)
            check_eq("stall_cnt", bus.stall_cnt[o*CNTW +: CNTW], m_stall[o]);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.in_req   = '0;
        bus.in_data  = '0;
        bus.out_full = '0;
    endtask

    task automatic set_req(input int i, input int o, input logic [DATASIZE-1:0] d);
        bus.in_req[i*NPORT +: NPORT]     = NPORT'(1) << o;
        bus.in_data[i*DATASIZE +: DATASIZE] = d;
    endtask

    task automatic random_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NPORT; i++) begin
                bus.in_req[i*NPORT +: NPORT] = ($urandom_range(0, 3) == 0) ? '0 : NPORT'($urandom);
                bus.in_data[i*DATASIZE +: DATASIZE] = DATASIZE'({$urandom, $urandom});
            end
            for (int o = 0; o < NPORT; o++) bus.out_full[o] = ($urandom_range(0, 3) == 0);
            settle();
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int seq [6] = '{0, 2, 4, 0, 2, 4};
        logic [DATASIZE-1:0] da, db;

        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        settle();
        check_eq("rst_valid", bus.out_valid, '0);
        check_eq("rst_data", bus.out_data, '0);
        check_eq("rst_ready", bus.in_ready, {NPORT{1'b1}});
        advance();

        // Contention: inputs 0, 2, 4 to output 1
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            set_req(0, 1, 40'h100 + DATASIZE'(k));
            set_req(2, 1, 40'h200 + DATASIZE'(k));
            set_req(4, 1, 40'h400 + DATASIZE'(k));
            settle();
            check_eq("contend_grant", bus.grant[1*NPORT +: NPORT], NPORT'(1) << seq[k]);
            check_eq("contend_ready", bus.in_ready & 5'b10101, NPORT'(1) << seq[k]);
            advance();
        end

        // Single flow: input 1 -> output 3
        clear_inputs();
        set_req(1, 3, 40'h12345);
        settle();
        check_eq("single_grant", bus.grant[3*NPORT + 1], 1'b1);
        check_eq("single_ready", bus.in_ready[1], 1'b1);
        advance();
        clear_inputs();
        settle();
        check_eq("single_valid", bus.out_valid[3], 1'b1);
        check_eq("single_data", bus.out_data[3*DATASIZE +: DATASIZE], 40'h12345);
        advance();

        // Backpressure on output 2
        da = 40'hAA_0000_0001;
        db = 40'hBB_0000_0002;
        clear_inputs();
        set_req(0, 2, da);
        settle();
        advance();
        clear_inputs();
        set_req(3, 2, db);
        bus.out_full[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("bp_hold_data", bus.out_data[2*DATASIZE +: DATASIZE], da);
            check_eq("bp_no_grant", bus.grant[2*NPORT +: NPORT], '0);
            check_eq("bp_not_ready", bus.in_ready[3], 1'b0);
            advance();
        end
        bus.out_full[2] = 1'b0;
        settle();
        check_eq("bp_release_grant", bus.grant[2*NPORT + 3], 1'b1);
        advance();
        clear_inputs();
        settle();
        check_eq("bp_new_data", bus.out_data[2*DATASIZE +: DATASIZE], db);
        check_eq("bp_new_valid", bus.out_valid[2], 1'b1);
        advance();

        // Multi-hot request uses only the lowest bit; then all idle
        clear_inputs();
        bus.in_req[0 +: NPORT] = 5'b10100;
        settle();
        check_eq("multihot_out2", bus.grant[2*NPORT + 0], 1'b1);
        check_eq("multihot_out4", bus.grant[4*NPORT +: NPORT], '0);
        advance();
        clear_inputs();
        settle();
        check_eq("idle_ready", bus.in_ready, {NPORT{1'b1}});
        advance();
        settle();
        check_eq("idle_valid", bus.out_valid, '0);
        advance();

`ifdef NOC_XBAR_STALL_CNT_EN
        // Stall counter saturation on output 0
        clear_inputs();
        set_req(1, 0, 40'h77);
        bus.out_full[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            settle();
            advance();
        end
        bus.out_full[0] = 1'b0;
        settle();
        check_eq("stall_sat", bus.stall_cnt[0 +: CNTW], CNTW'((1 << CNTW) - 1));
        advance();
        clear_inputs();
        settle();
        check_eq("stall_clear", bus.stall_cnt[0 +: CNTW], '0);
        advance();
`endif

        random_cycles(100);

        // Reset mid-transfer: move ptr[0] to 4 first, then reset
        clear_inputs();
        set_req(3, 0, 40'h33);
        settle();
        advance();
        set_req(3, 0, 40'h34);
        settle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", bus.out_valid, '0);
        check_eq("midrst_data", bus.out_data, '0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(2, 0, 40'h22);
        set_req(4, 0, 40'h44);
        settle();
        check_eq("midrst_first_grant", bus.grant[0 +: NPORT], 5'b00100);
        advance();

        random_cycles(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
